seg_scan_disp: RTL and testbench



---
 rtl/seg_pkg.sv | 15 +
 rtl/hex7seg_dec.sv | 12 +
 rtl/seg_scan_disp.sv | 146 ++++++++++++++
 tb/tb_seg_scan_disp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Patterns are active-low, bit order gfedcba.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational lookup.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg_scan_disp.sv
// Multiplexed common-anode seven-segment driver with dead time,
// leading-zero blanking, blink and double-buffered loading.
module seg_scan_disp
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 200000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic                    pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] BLANK_T   = TW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FR_LAST   = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0]         tick;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         fcnt;
  logic                  blink_phase;
  logic [DW-1:0]         shadow;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [DW-1:0]         active;
  logic [NUM_DIGITS-1:0] active_dp;

  logic                  boundary;
  logic                  lead_zero;
  logic                  visible;
  logic [3:0]            nib;
  logic [6:0]            dec;
  logic [NUM_DIGITS-1:0] an_nx;

  assign boundary   = (tick == TICK_LAST) && (idx == IDX_LAST);
  assign frame_done = boundary;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick        <= '0;
      idx         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (tick == TICK_LAST) begin
        tick <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
      if (boundary) begin
        if (fcnt == FR_LAST) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // A load landing on the boundary bypasses the shadow stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      shadow_dp <= '0;
      active    <= '0;
      active_dp <= '0;
      pending   <= 1'b0;
    end else begin
      if (load) begin
        shadow    <= data_in;
        shadow_dp <= dp_in;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          active    <= data_in;
          active_dp <= dp_in;
        end else if (pending) begin
          active    <= shadow;
          active_dp <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IW'(i) >= idx) && (active[4*i +: 4] != 4'h0))
        lead_zero = 1'b0;
    end
  end

  assign visible = (tick >= BLANK_T)
                && !(blink_phase && blink_mask[idx])
                && !(lz_blank && (idx != '0) && lead_zero);

  assign nib = active[4*idx +: 4];

  hex7seg_dec u_dec (
    .nib (nib),
    .seg (dec)
  );

  always_comb begin
    an_nx      = AN_OFF[NUM_DIGITS-1:0];
    an_nx[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF[NUM_DIGITS-1:0];
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (visible) begin
      an  <= an_nx;
      seg <= dec;
      dp  <= ~active_dp[idx];
    end else begin
      an  <= AN_OFF[NUM_DIGITS-1:0];
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Bench for seg_scan_disp: directed scenarios plus random
// traffic, checked every cycle against an arithmetic model.
module tb_seg_scan_disp;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int F  = N * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic        pending;
  logic        frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          n = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_sh = '0;
  logic [3:0]  m_adp = '0;
  logic [3:0]  m_sdp = '0;
  logic        m_pend = 1'b0;

  always #5 clk = ~clk;

  seg_scan_disp #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (S),
    .BLANK_CYC    (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .lz_blank   (lz_blank),
    .load       (load),
    .pending    (pending),
    .frame_done (frame_done),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    logic [3:0] d;
    int         t, k, f;
    logic       dark, bnd;
    ean  = 4'hF;
    eseg = 7'h7F;
    edp  = 1'b1;
    if (rst) begin
      n      = 0;
      m_act  = '0;
      m_sh   = '0;
      m_adp  = '0;
      m_sdp  = '0;
      m_pend = 1'b0;
    end else begin
      t = n % S;
      k = (n / S) % N;
      f = n / F;
      d = 4'(m_act >> (4 * k));
      dark = (t < BC)
          || (((f / BF) % 2 == 1) && blink_mask[k])
          || (lz_blank && k != 0 && (m_act >> (4 * k)) == 0);
      if (!dark) begin
        ean  = ~(4'b0001 << k);
        eseg = tbl[d];
        edp  = ~m_adp[k];
      end
      bnd = (n % F) == F - 1;
      if (load) begin
        m_sh  = data_in;
        m_sdp = dp_in;
      end
      if (bnd) begin
        if (load || m_pend) begin
          m_act = m_sh;
          m_adp = m_sdp;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      n++;
    end
    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(ean));
    check("seg", 32'(seg), 32'(eseg));
    check("dp", 32'(dp), 32'(edp));
    check("pending", 32'(pending), 32'(m_pend));
    check("frame_done", 32'(frame_done),
          32'((n % F) == F - 1));
  endtask

  task automatic run(int c);
    repeat (c) step();
  endtask

  task automatic sync(int r);
    for (int i = 0; i < F && (n % F) != r; i++) step();
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic do_reset(int c);
    rst = 1'b1;
    run(c);
    rst = 1'b0;
  endtask

  initial begin
    do_reset(3);
    run(5);

    do_load(16'h1A2F, 4'b0100);
    run(2 * F);

    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(2 * F);
    do_load(16'h0000, 4'b0000);
    run(2 * F);
    lz_blank = 1'b0;

    sync(10);
    do_load(16'h1111, 4'b0000);
    run(5);
    do_load(16'h2222, 4'b0000);
    run(2 * F);

    sync(F - 1);
    do_load(16'h3333, 4'b0001);
    run(F + 5);

    do_reset(1);
    do_load(16'h4321, 4'b0000);
    blink_mask = 4'b0001;
    run(6 * F);
    blink_mask = 4'b0000;

    sync(2 * S + 3);
    do_reset(1);
    run(F);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      if ($urandom_range(0, 39) == 0)
        lz_blank = 1'($urandom);
      if ($urandom_range(0, 59) == 0)
        blink_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        data_in = ($urandom_range(0, 1) == 0)
                ? 16'($urandom)
                : 16'($urandom_range(0, 255));
        dp_in = 4'($urandom);
        load  = 1'b1;
      end
      step();
      load = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
